vga_fb_scanout: RTL

//  Pixel-pipeline stage directly downstream of the 800x600 VGA timing generator. Consumes sx/sy/de/hsync/vsync,

---
 rtl/vga_fb_scanout_if.sv | 24 ++
 rtl/vga_fb_scanout.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port between the scanout stage and its synchronous RAM.
// Latency: RAM returns fb_data MEM_LAT cycles after fb_en/fb_addr.
// Backpressure: none; the reader issues one read per active pixel cycle.
interface vga_fb_scanout_if #(
    parameter int ADDR_W = 16
) ();
    logic              fb_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [11:0]       fb_data;

    // Scanout side issues reads and consumes data.
    modport master (
        output fb_en,
        output fb_addr,
        input  fb_data
    );

    // RAM side answers reads.
    modport slave (
        input  fb_en,
        input  fb_addr,
        output fb_data
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// Scaled, double-buffered framebuffer scanout behind the 800x600 VGA timing generator.
// Latency: fixed 2+MEM_LAT cycles from sx/sy/de/sync input to RGB/sync output.
// Backpressure: none; fully paced by the timing generator, one pixel per clock.
module vga_fb_scanout #(
    parameter int H_ACT    = 800,
    parameter int V_ACT    = 600,
    parameter int FB_W     = 200,
    parameter int FB_H     = 150,
    parameter int SCALE_SH = 2,
    parameter int ADDR_W   = 16,
    parameter int MEM_LAT  = 1
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic [9:0]              sx,
    input  logic [9:0]              sy,
    input  logic                    de,
    input  logic                    hsync,
    input  logic                    vsync,
    vga_fb_scanout_if.master        fb,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    back_sel,
    output logic [3:0]              vga_r,
    output logic [3:0]              vga_g,
    output logic [3:0]              vga_b,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_de
);

    localparam int SCALE = 1 << SCALE_SH;
    localparam int LAT   = 2 + MEM_LAT;
    localparam int YW    = (SCALE_SH > 0) ? SCALE_SH : 1;

    localparam logic [ADDR_W-1:0] BASE_ONE  = ADDR_W'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_W);
    localparam logic [YW-1:0]     YSUB_LAST = YW'(SCALE - 1);
    localparam logic [9:0]        SY_LAST   = 10'(V_ACT - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    // Geometry must tile the active area exactly; catch bad parameter sets at elaboration.
    if (H_ACT != FB_W * SCALE) begin : g_bad_h_act
        $error("H_ACT must equal FB_W << SCALE_SH");
    end
    if (V_ACT != FB_H * SCALE) begin : g_bad_v_act
        $error("V_ACT must equal FB_H << SCALE_SH");
    end
    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("MEM_LAT must be at least 1");
    end

    logic              de_q;
    logic [9:0]        sy_q;
    logic [ADDR_W-1:0] row_ptr;
    logic [YW-1:0]     ysub;
    logic              front_sel;
    logic              pending;
    sync_t             sync_pipe [LAT];
    rgb_t              rgb_q;

    logic line_end;
    logic frame_end;
    logic swap_now;
    logic next_front;

    // Line end is the falling edge of de; sy_q still holds the row that just finished.
    assign line_end   = de_q & ~de;
    assign frame_end  = line_end & (sy_q == SY_LAST);
    assign swap_now   = frame_end & (pending | swap_req);
    assign next_front = front_sel ^ swap_now;

    // Read request: one fb read per active pixel, address held through blanking.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            fb.fb_en   <= 1'b0;
            fb.fb_addr <= '0;
        end else begin
            fb.fb_en <= de;
            if (de) begin
                fb.fb_addr <= row_ptr + ADDR_W'(sx >> SCALE_SH);
            end
        end
    end

    // Row pointer accumulator: advance one framebuffer row every SCALE lines, rewind at frame end.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            de_q    <= 1'b0;
            sy_q    <= '0;
            row_ptr <= '0;
            ysub    <= '0;
        end else begin
            de_q <= de;
            sy_q <= sy;
            if (frame_end) begin
                row_ptr <= next_front ? BASE_ONE : '0;
                ysub    <= '0;
            end else if (line_end) begin
                if (ysub == YSUB_LAST) begin
                    row_ptr <= row_ptr + ROW_STEP;
                    ysub    <= '0;
                end else begin
                    ysub <= ysub + 1'b1;
                end
            end
        end
    end

    // Buffer swap: latch requests, apply only at frame end so a frame never tears.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            front_sel <= 1'b0;
            pending   <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= swap_now;
            if (swap_now) begin
                front_sel <= ~front_sel;
                pending   <= 1'b0;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

    // Sync/de delay line matching the read path so colour and sync leave together.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < LAT; i++) begin
                sync_pipe[i] <= SYNC_IDLE;
            end
        end else begin
            sync_pipe[0] <= '{hs: hsync, vs: vsync, de: de};
            for (int i = 1; i < LAT; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    // Colour register: RAM data when the matching pixel was active, black in blanking.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= sync_pipe[MEM_LAT].de ? rgb_t'(fb.fb_data) : rgb_t'(12'h000);
        end
    end

    assign back_sel = ~front_sel;
    assign vga_r    = rgb_q.r;
    assign vga_g    = rgb_q.g;
    assign vga_b    = rgb_q.b;
    assign vga_hs   = sync_pipe[LAT-1].hs;
    assign vga_vs   = sync_pipe[LAT-1].vs;
    assign vga_de   = sync_pipe[LAT-1].de;

endmodule
